// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding, ALU, branch resolution, EX/MEM register and an iterative MUL/DIV unit.
// Build option: `define MDU_FAST_MUL_EN selects a single-cycle array product for MUL/MULH.
module ex_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   ex_databus1_in,
    input  logic [XLEN-1:0]   ex_databus2_in,
    input  logic [XLEN-1:0]   ex_shamt_in,
    input  logic [XLEN-1:0]   ex_imm_in,
    input  logic [XLEN-1:0]   ex_mem_aluout_fwd,
    input  logic [XLEN-1:0]   mem_wb_wdata_fwd,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [XLEN-1:0]   ex_pc_plus_4_in,
    input  logic [REG_AW-1:0] ex_rt_in,
    input  logic [REG_AW-1:0] ex_rd_in,
    input  logic [1:0]        reg_option,
    input  logic              ex_branch_in,
    input  logic              ex_alusrc1_in,
    input  logic              ex_alusrc2_in,
    input  logic              ex_memwr_in,
    input  logic              ex_memread_in,
    input  logic              ex_regwrite_in,
    input  logic              ex_sign_in,
    input  logic [1:0]        ex_regdst_in,
    input  logic [1:0]        ex_memtoreg_in,
    input  logic [4:0]        ex_aluctl_in,
    input  logic              ex_md_in,
    input  logic [1:0]        ex_md_op_in,
    output logic              ex_busy,
    output logic              branch_taken,
    output logic [XLEN-1:0]   branch_addr,
    output logic              ex_mem_memwr_out,
    output logic              ex_mem_memread_out,
    output logic              ex_mem_regwrite_out,
    output logic [1:0]        ex_mem_memtoreg_out,
    output logic [XLEN-1:0]   ex_mem_pc_plus_4_out,
    output logic [XLEN-1:0]   ex_mem_aluout_out,
    output logic [XLEN-1:0]   ex_mem_databus2_out,
    output logic [REG_AW-1:0] ex_mem_wraddr_out
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_SLT = 5'd6;
    localparam logic [4:0] ALU_SLL = 5'd7;
    localparam logic [4:0] ALU_SRL = 5'd8;
    localparam logic [4:0] ALU_SRA = 5'd9;
    localparam logic [4:0] ALU_LUI = 5'd10;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULH = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    function automatic logic [XLEN-1:0] f_cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_cond_neg2(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [XLEN-1:0]        w_fwd_a;
    logic [XLEN-1:0]        w_fwd_b;
    logic [XLEN-1:0]        w_alu_in1;
    logic [XLEN-1:0]        w_alu_in2;
    logic [XLEN-1:0]        w_alu_res;
    logic signed [XLEN-1:0] w_sra;
    logic                   w_zero;
    logic [REG_AW-1:0]      w_wraddr;
    logic [XLEN-1:0]        w_ex_result;

    logic [1:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic [1:0]             r_op;
    logic                   r_neg_a;
    logic                   r_neg_b;
    logic                   r_bzero;
    logic [XLEN-1:0]        r_dividend;
    logic [XLEN-1:0]        r_mcand;
    logic [XLEN-1:0]        r_hi;
    logic [XLEN-1:0]        r_lo;

    logic                   w_md_start;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic [XLEN-1:0]        w_mag_a;
    logic [XLEN-1:0]        w_mag_b;
    logic [XLEN:0]          w_sum;
    logic [XLEN:0]          w_rsh;
    logic [XLEN:0]          w_diff;
    logic [XLEN-1:0]        w_step_hi;
    logic [XLEN-1:0]        w_step_lo;
    logic [2*XLEN-1:0]      w_prod;
    logic [2*XLEN-1:0]      w_prod_s;
    logic [XLEN-1:0]        w_md_res;
`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0]      w_fast_prod;
`endif

    // Operand forwarding and ALU input select
    always_comb begin
        case (forward_a)
            2'b00:   w_fwd_a = ex_databus1_in;
            2'b01:   w_fwd_a = mem_wb_wdata_fwd;
            default: w_fwd_a = ex_mem_aluout_fwd;
        endcase
        case (forward_b)
            2'b00:   w_fwd_b = ex_databus2_in;
            2'b01:   w_fwd_b = mem_wb_wdata_fwd;
            default: w_fwd_b = ex_mem_aluout_fwd;
        endcase
    end

    assign w_alu_in1 = ex_alusrc1_in ? ex_shamt_in : w_fwd_a;
    assign w_alu_in2 = ex_alusrc2_in ? ex_imm_in   : w_fwd_b;
    assign w_sra     = $signed(w_alu_in2) >>> w_alu_in1[SHW-1:0];

    always_comb begin
        w_alu_res = w_alu_in1 + w_alu_in2;
        case (ex_aluctl_in)
            ALU_ADD: w_alu_res = w_alu_in1 + w_alu_in2;
            ALU_SUB: w_alu_res = w_alu_in1 - w_alu_in2;
            ALU_AND: w_alu_res = w_alu_in1 & w_alu_in2;
            ALU_OR:  w_alu_res = w_alu_in1 | w_alu_in2;
            ALU_XOR: w_alu_res = w_alu_in1 ^ w_alu_in2;
            ALU_NOR: w_alu_res = ~(w_alu_in1 | w_alu_in2);
            ALU_SLT: begin
                if (ex_sign_in)
                    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_alu_in1) < $signed(w_alu_in2))};
                else
                    w_alu_res = {{(XLEN-1){1'b0}}, (w_alu_in1 < w_alu_in2)};
            end
            ALU_SLL: w_alu_res = w_alu_in2 << w_alu_in1[SHW-1:0];
            ALU_SRL: w_alu_res = w_alu_in2 >> w_alu_in1[SHW-1:0];
            ALU_SRA: w_alu_res = $unsigned(w_sra);
            ALU_LUI: w_alu_res = w_alu_in2 << (XLEN/2);
            default: w_alu_res = w_alu_in1 + w_alu_in2;
        endcase
    end

    assign w_zero       = (w_alu_res == '0);
    assign branch_taken = w_zero & ex_branch_in & ~ex_busy;
    assign branch_addr  = ex_pc_plus_4_in + (ex_imm_in << 2);

    always_comb begin
        case (ex_regdst_in)
            2'b00:   w_wraddr = ex_rt_in;
            2'b01:   w_wraddr = ex_rd_in;
            default: w_wraddr = '1;
        endcase
    end

    // MDU operand preparation: work on magnitudes, restore signs on the way out
    assign w_md_start = (r_state == S_IDLE) && ex_md_in && (reg_option != 2'b01);
    assign ex_busy    = w_md_start || (r_state == S_BUSY);
    assign w_neg_a    = ex_sign_in & w_fwd_a[XLEN-1];
    assign w_neg_b    = ex_sign_in & w_fwd_b[XLEN-1];
    assign w_mag_a    = f_cond_neg(w_neg_a, w_fwd_a);
    assign w_mag_b    = f_cond_neg(w_neg_b, w_fwd_b);
`ifdef MDU_FAST_MUL_EN
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
        w_rsh  = {r_hi, r_lo[XLEN-1]};
        w_diff = w_rsh - {1'b0, r_mcand};
        if (r_op[1]) begin
            if (!w_diff[XLEN]) begin
                w_step_hi = w_diff[XLEN-1:0];
                w_step_lo = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_step_hi = w_rsh[XLEN-1:0];
                w_step_lo = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_cnt <= '0;
`ifdef MDU_FAST_MUL_EN
                        r_state <= ex_md_op_in[1] ? S_BUSY : S_DONE;
`else
                        r_state <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (reg_option == 2'b01) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(XLEN-1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_md_start) begin
            r_op       <= ex_md_op_in;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_bzero    <= (w_fwd_b == '0);
            r_dividend <= w_fwd_a;
            r_mcand    <= w_mag_b;
`ifdef MDU_FAST_MUL_EN
            if (!ex_md_op_in[1]) begin
                {r_hi, r_lo} <= w_fast_prod;
            end else begin
                r_hi <= '0;
                r_lo <= w_mag_a;
            end
`else
            r_hi <= '0;
            r_lo <= w_mag_a;
`endif
        end else if (r_state == S_BUSY) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
        end
    end

    // Result sign fix-up; divide-by-zero returns all-ones / dividend
    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = f_cond_neg2(r_neg_a ^ r_neg_b, w_prod);
        case (r_op)
            MD_MUL:  w_md_res = w_prod_s[XLEN-1:0];
            MD_MULH: w_md_res = w_prod_s[2*XLEN-1:XLEN];
            MD_DIV:  w_md_res = r_bzero ? '1 : f_cond_neg(r_neg_a ^ r_neg_b, r_lo);
            default: w_md_res = r_bzero ? r_dividend : f_cond_neg(r_neg_a, r_hi);
        endcase
    end

    assign w_ex_result = (r_state == S_DONE) ? w_md_res : w_alu_res;

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_memwr_out     <= 1'b0;
            ex_mem_memread_out   <= 1'b0;
            ex_mem_regwrite_out  <= 1'b0;
            ex_mem_memtoreg_out  <= 2'b00;
            ex_mem_pc_plus_4_out <= '0;
            ex_mem_aluout_out    <= '0;
            ex_mem_databus2_out  <= '0;
            ex_mem_wraddr_out    <= '0;
        end else begin
            ex_mem_pc_plus_4_out <= ex_pc_plus_4_in;
            ex_mem_aluout_out    <= w_ex_result;
            ex_mem_databus2_out  <= w_fwd_b;
            ex_mem_wraddr_out    <= w_wraddr;
            if (ex_busy || reg_option == 2'b01) begin
                ex_mem_memwr_out    <= 1'b0;
                ex_mem_memread_out  <= 1'b0;
                ex_mem_regwrite_out <= 1'b0;
                ex_mem_memtoreg_out <= 2'b00;
            end else if (reg_option == 2'b00) begin
                ex_mem_memwr_out    <= ex_memwr_in;
                ex_mem_memread_out  <= ex_memread_in;
                ex_mem_regwrite_out <= ex_regwrite_in;
                ex_mem_memtoreg_out <= ex_memtoreg_in;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: forwarding/ALU/EX-MEM, MDU ops, abort, branch and reset.
module tb_ex_stage_mdu;

`ifdef MDU_FAST_MUL_EN
    localparam int MULCYC = 1;
`else
    localparam int MULCYC = 33;
`endif
    localparam int DIVCYC = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ex_databus1_in, ex_databus2_in, ex_shamt_in, ex_imm_in;
    logic [31:0] ex_mem_aluout_fwd, mem_wb_wdata_fwd, ex_pc_plus_4_in;
    logic [1:0]  forward_a, forward_b, reg_option, ex_regdst_in, ex_memtoreg_in, ex_md_op_in;
    logic [4:0]  ex_rt_in, ex_rd_in, ex_aluctl_in;
    logic        ex_branch_in, ex_alusrc1_in, ex_alusrc2_in, ex_memwr_in, ex_memread_in;
    logic        ex_regwrite_in, ex_sign_in, ex_md_in;
    logic        ex_busy, branch_taken;
    logic [31:0] branch_addr;
    logic        ex_mem_memwr_out, ex_mem_memread_out, ex_mem_regwrite_out;
    logic [1:0]  ex_mem_memtoreg_out;
    logic [31:0] ex_mem_pc_plus_4_out, ex_mem_aluout_out, ex_mem_databus2_out;
    logic [4:0]  ex_mem_wraddr_out;

    int n_chk = 0;
    int n_err = 0;

    ex_stage_mdu #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_databus1_in(ex_databus1_in), .ex_databus2_in(ex_databus2_in),
        .ex_shamt_in(ex_shamt_in), .ex_imm_in(ex_imm_in),
        .ex_mem_aluout_fwd(ex_mem_aluout_fwd), .mem_wb_wdata_fwd(mem_wb_wdata_fwd),
        .forward_a(forward_a), .forward_b(forward_b),
        .ex_pc_plus_4_in(ex_pc_plus_4_in), .ex_rt_in(ex_rt_in), .ex_rd_in(ex_rd_in),
        .reg_option(reg_option), .ex_branch_in(ex_branch_in),
        .ex_alusrc1_in(ex_alusrc1_in), .ex_alusrc2_in(ex_alusrc2_in),
        .ex_memwr_in(ex_memwr_in), .ex_memread_in(ex_memread_in),
        .ex_regwrite_in(ex_regwrite_in), .ex_sign_in(ex_sign_in),
        .ex_regdst_in(ex_regdst_in), .ex_memtoreg_in(ex_memtoreg_in),
        .ex_aluctl_in(ex_aluctl_in), .ex_md_in(ex_md_in), .ex_md_op_in(ex_md_op_in),
        .ex_busy(ex_busy), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .ex_mem_memwr_out(ex_mem_memwr_out), .ex_mem_memread_out(ex_mem_memread_out),
        .ex_mem_regwrite_out(ex_mem_regwrite_out), .ex_mem_memtoreg_out(ex_mem_memtoreg_out),
        .ex_mem_pc_plus_4_out(ex_mem_pc_plus_4_out), .ex_mem_aluout_out(ex_mem_aluout_out),
        .ex_mem_databus2_out(ex_mem_databus2_out), .ex_mem_wraddr_out(ex_mem_wraddr_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        ex_databus1_in = '0; ex_databus2_in = '0; ex_shamt_in = '0; ex_imm_in = '0;
        ex_mem_aluout_fwd = '0; mem_wb_wdata_fwd = '0; ex_pc_plus_4_in = '0;
        forward_a = 2'b00; forward_b = 2'b00; reg_option = 2'b00;
        ex_regdst_in = 2'b00; ex_memtoreg_in = 2'b00; ex_md_op_in = 2'b00;
        ex_rt_in = '0; ex_rd_in = '0; ex_aluctl_in = 5'd0;
        ex_branch_in = 1'b0; ex_alusrc1_in = 1'b0; ex_alusrc2_in = 1'b0;
        ex_memwr_in = 1'b0; ex_memread_in = 1'b0; ex_regwrite_in = 1'b0;
        ex_sign_in = 1'b0; ex_md_in = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic sgn, input int exp_cyc,
                          input logic [31:0] exp_res);
        int n;
        clr;
        ex_databus1_in = a; ex_databus2_in = b; ex_md_in = 1'b1; ex_md_op_in = op;
        ex_sign_in = sgn; ex_regwrite_in = 1'b1; ex_regdst_in = 2'b01; ex_rd_in = 5'd7;
        n = 0;
        #1;
        while (ex_busy === 1'b1 && n < 100) begin
            n++;
            step;
        end
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_bubble"}, 64'(ex_mem_regwrite_out), 64'd0);
        step;
        chk({tag, "_result"}, 64'(ex_mem_aluout_out), 64'(exp_res));
        chk({tag, "_regwrite"}, 64'(ex_mem_regwrite_out), 64'd1);
        clr;
    endtask

    initial begin
        clr;
        rst_n = 1'b0;
        step;
        chk("rst_aluout", 64'(ex_mem_aluout_out), 64'd0);
        chk("rst_regwrite", 64'(ex_mem_regwrite_out), 64'd0);
        chk("rst_busy", 64'(ex_busy), 64'd0);
        chk("rst_wraddr", 64'(ex_mem_wraddr_out), 64'd0);
        chk("rst_pc4", 64'(ex_mem_pc_plus_4_out), 64'd0);
        rst_n = 1'b1;
        step;

        // ADD with EX/MEM forward on A: 5 + 7
        forward_a = 2'b10; ex_mem_aluout_fwd = 32'd5; ex_databus1_in = 32'd99;
        ex_databus2_in = 32'd7; ex_regdst_in = 2'b01; ex_rd_in = 5'd3; ex_rt_in = 5'd9;
        ex_regwrite_in = 1'b1; ex_memtoreg_in = 2'b01; ex_pc_plus_4_in = 32'h40;
        step;
        chk("add_aluout", 64'(ex_mem_aluout_out), 64'd12);
        chk("add_wraddr", 64'(ex_mem_wraddr_out), 64'd3);
        chk("add_regwrite", 64'(ex_mem_regwrite_out), 64'd1);
        chk("add_memtoreg", 64'(ex_mem_memtoreg_out), 64'd1);
        chk("add_pc4", 64'(ex_mem_pc_plus_4_out), 64'h40);

        // Hold: controls keep, data loads
        reg_option = 2'b10; ex_regwrite_in = 1'b0; ex_databus2_in = 32'd8;
        step;
        chk("hold_regwrite", 64'(ex_mem_regwrite_out), 64'd1);
        chk("hold_data", 64'(ex_mem_databus2_out), 64'd8);

        // Flush: controls zeroed
        reg_option = 2'b01; ex_regwrite_in = 1'b1;
        step;
        chk("flush_regwrite", 64'(ex_mem_regwrite_out), 64'd0);

        // SUB with MEM/WB forward on B, regdst=1x
        clr;
        ex_aluctl_in = 5'd1; ex_databus1_in = 32'd50; forward_b = 2'b01;
        mem_wb_wdata_fwd = 32'd20; ex_regdst_in = 2'b10; ex_regwrite_in = 1'b1;
        step;
        chk("sub_aluout", 64'(ex_mem_aluout_out), 64'd30);
        chk("sub_wraddr", 64'(ex_mem_wraddr_out), 64'h1F);
        chk("sub_store", 64'(ex_mem_databus2_out), 64'd20);

        run_md("mul_u",   32'hFFFF_FFFF, 32'd2, 2'b00, 1'b0, MULCYC, 32'hFFFF_FFFE);
        run_md("mulh_u",  32'hFFFF_FFFF, 32'd2, 2'b01, 1'b0, MULCYC, 32'h0000_0001);
        run_md("mul_s",   32'hFFFF_FFFD, 32'd4, 2'b00, 1'b1, MULCYC, 32'hFFFF_FFF4);
        run_md("mulh_s",  32'hFFFF_FFFD, 32'd4, 2'b01, 1'b1, MULCYC, 32'hFFFF_FFFF);
        run_md("div_s",   32'hFFFF_FFF9, 32'd2, 2'b10, 1'b1, DIVCYC, 32'hFFFF_FFFD);
        run_md("rem_s",   32'hFFFF_FFF9, 32'd2, 2'b11, 1'b1, DIVCYC, 32'hFFFF_FFFF);
        run_md("div_z",   32'd5, 32'd0, 2'b10, 1'b0, DIVCYC, 32'hFFFF_FFFF);
        run_md("rem_z",   32'd5, 32'd0, 2'b11, 1'b0, DIVCYC, 32'd5);
        run_md("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b1, DIVCYC, 32'h8000_0000);
        run_md("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 1'b1, DIVCYC, 32'd0);
        run_md("div_u",   32'd100, 32'd7, 2'b10, 1'b0, DIVCYC, 32'd14);
        run_md("rem_u",   32'd100, 32'd7, 2'b11, 1'b0, DIVCYC, 32'd2);

        // Abort a divide with reg_option=01 after 10 cycles
        ex_databus1_in = 32'd100; ex_databus2_in = 32'd7; ex_md_in = 1'b1;
        ex_md_op_in = 2'b10; ex_regwrite_in = 1'b1;
        repeat (10) step;
        reg_option = 2'b01;
        #1;
        chk("abort_busy_before", 64'(ex_busy), 64'd1);
        step;
        chk("abort_busy_after", 64'(ex_busy), 64'd0);
        chk("abort_regwrite", 64'(ex_mem_regwrite_out), 64'd0);
        chk("abort_aluout", 64'(ex_mem_aluout_out), 64'd107);
        step;
        chk("abort_idle_busy", 64'(ex_busy), 64'd0);
        chk("abort_idle_regwrite", 64'(ex_mem_regwrite_out), 64'd0);
        clr;
        step;

        // BEQ: equal operands, then unequal, then during MDU busy
        ex_aluctl_in = 5'd1; ex_databus1_in = 32'd5; ex_databus2_in = 32'd5;
        ex_branch_in = 1'b1; ex_pc_plus_4_in = 32'h100; ex_imm_in = 32'd3;
        #1;
        chk("beq_taken", 64'(branch_taken), 64'd1);
        chk("beq_addr", 64'(branch_addr), 64'h10C);
        ex_databus2_in = 32'd6;
        #1;
        chk("bne_taken", 64'(branch_taken), 64'd0);
        ex_databus2_in = 32'd5; ex_md_in = 1'b1; ex_md_op_in = 2'b10;
        #1;
        chk("beq_busy", 64'(branch_taken), 64'd0);
        ex_md_in = 1'b0;
        #1;
        step;

        // Asynchronous reset in the middle of a divide
        clr;
        ex_databus1_in = 32'd100; ex_databus2_in = 32'd7; ex_md_in = 1'b1;
        ex_md_op_in = 2'b10; ex_pc_plus_4_in = 32'h200;
        repeat (5) step;
        #2;
        rst_n = 1'b0;
        ex_md_in = 1'b0;
        #1;
        chk("arst_busy", 64'(ex_busy), 64'd0);
        chk("arst_aluout", 64'(ex_mem_aluout_out), 64'd0);
        chk("arst_pc4", 64'(ex_mem_pc_plus_4_out), 64'd0);
        step;
        rst_n = 1'b1;
        step;
        run_md("div_after_rst", 32'd100, 32'd7, 2'b10, 1'b0, DIVCYC, 32'd14);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
